memory_stage: RTL and testbench

- Pipeline MEM stage: sits between the execute stage and writeback.
- Accepts one execute result per handshake and performs the LD/SD doubleword access on the data bus, holding the request until the bus answers.
- Registers a writeback record (regwrite, dst, regdata) and stalls upstream while an access is outstanding.
- Non-memory ops pass through with 1-cycle latency.

---
 rtl/memory_stage_if.sv | 43 ++++
 rtl/memory_stage.sv | 154 +++++++++++++++
 tb/tb_memory_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// MEM-stage signal bundle: execute-side input record, data-bus request/response, writeback record and status.
// slave = the memory stage itself; master = the surrounding pipeline / bus environment.
interface memory_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [63:0] in_memdata;
    logic        in_memread;
    logic        in_memwrite;
    logic        in_regwrite;
    logic [4:0]  in_dst;

    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    logic        out_valid;
    logic        out_regwrite;
    logic [4:0]  out_dst;
    logic [63:0] out_regdata;

    logic        stall;
    logic        misalign;
    logic        bus_err;

    modport slave (
        input  in_valid, in_result, in_memdata, in_memread, in_memwrite, in_regwrite, in_dst,
        input  dresp_data_ok, dresp_data,
        output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output out_valid, out_regwrite, out_dst, out_regdata, stall, misalign, bus_err
    );

    modport master (
        output in_valid, in_result, in_memdata, in_memread, in_memwrite, in_regwrite, in_dst,
        output dresp_data_ok, dresp_data,
        input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  out_valid, out_regwrite, out_dst, out_regdata, stall, misalign, bus_err
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: ALU ops 1 cycle, LD/SD bus wait + 2 cycles; one record in flight.
// Upstream is stalled (in_ready low) while a bus access is outstanding; writeback never back-pressures.
module memory_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    memory_stage_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [63:0]        r_addr, w_addr_nxt;
    logic [63:0]        r_wdata, w_wdata_nxt;
    logic [7:0]         r_strobe, w_strobe_nxt;
    logic               r_regwrite, w_regwrite_nxt;
    logic [4:0]         r_dst, w_dst_nxt;
    logic               r_is_load, w_is_load_nxt;

    logic               r_out_valid, w_out_valid;
    logic               r_out_regwrite, w_out_regwrite;
    logic [4:0]         r_out_dst, w_out_dst;
    logic [63:0]        r_out_regdata, w_out_regdata;
    logic               r_misalign, w_misalign;
    logic               r_bus_err, w_bus_err;

    logic               w_accept;
    logic               w_is_mem;
    logic               w_misal;
    logic               w_timeout;

    assign w_accept  = bus.in_valid && (r_state == S_IDLE);
    assign w_is_mem  = bus.in_memread || bus.in_memwrite;
    assign w_misal   = (bus.in_result[2:0] != 3'd0);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_strobe_nxt   = r_strobe;
        w_regwrite_nxt = r_regwrite;
        w_dst_nxt      = r_dst;
        w_is_load_nxt  = r_is_load;
        w_out_valid    = 1'b0;
        w_out_regwrite = 1'b0;
        w_out_dst      = 5'd0;
        w_out_regdata  = 64'd0;
        w_misalign     = 1'b0;
        w_bus_err      = r_bus_err;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_mem) begin
                        w_out_valid    = 1'b1;
                        w_out_dst      = bus.in_dst;
                        w_out_regwrite = bus.in_regwrite && (bus.in_dst != 5'd0);
                        w_out_regdata  = bus.in_result;
                    end else if (w_misal) begin
                        w_out_valid = 1'b1;
                        w_out_dst   = bus.in_dst;
                        w_misalign  = 1'b1;
                    end else begin
                        // memread wins when both are set, so the strobe follows memread alone
                        w_addr_nxt     = bus.in_result;
                        w_wdata_nxt    = bus.in_memdata;
                        w_is_load_nxt  = bus.in_memread;
                        w_strobe_nxt   = bus.in_memread ? 8'h00 : 8'hFF;
                        w_regwrite_nxt = bus.in_regwrite;
                        w_dst_nxt      = bus.in_dst;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (bus.dresp_data_ok) begin
                    w_state_nxt    = S_IDLE;
                    w_cnt_nxt      = '0;
                    w_out_valid    = 1'b1;
                    w_out_dst      = r_dst;
                    w_out_regwrite = r_is_load && r_regwrite && (r_dst != 5'd0);
                    w_out_regdata  = r_is_load ? bus.dresp_data : 64'd0;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_out_valid = 1'b1;
                    w_out_dst   = r_dst;
                    w_bus_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_addr         <= 64'd0;
            r_wdata        <= 64'd0;
            r_strobe       <= 8'd0;
            r_regwrite     <= 1'b0;
            r_dst          <= 5'd0;
            r_is_load      <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_regwrite <= 1'b0;
            r_out_dst      <= 5'd0;
            r_out_regdata  <= 64'd0;
            r_misalign     <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_addr         <= w_addr_nxt;
            r_wdata        <= w_wdata_nxt;
            r_strobe       <= w_strobe_nxt;
            r_regwrite     <= w_regwrite_nxt;
            r_dst          <= w_dst_nxt;
            r_is_load      <= w_is_load_nxt;
            r_out_valid    <= w_out_valid;
            r_out_regwrite <= w_out_regwrite;
            r_out_dst      <= w_out_dst;
            r_out_regdata  <= w_out_regdata;
            r_misalign     <= w_misalign;
            r_bus_err      <= w_bus_err;
        end
    end

    assign bus.in_ready     = (r_state == S_IDLE);
    assign bus.stall        = (r_state != S_IDLE);
    assign bus.dreq_valid   = (r_state == S_BUSY);
    assign bus.dreq_addr    = r_addr;
    assign bus.dreq_size    = 3'b011;
    assign bus.dreq_strobe  = r_strobe;
    assign bus.dreq_data    = r_wdata;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_regwrite = r_out_regwrite;
    assign bus.out_dst      = r_out_dst;
    assign bus.out_regdata  = r_out_regdata;
    assign bus.misalign     = r_misalign;
    assign bus.bus_err      = r_bus_err;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage (TIMEOUT=4): directed scenarios plus randomized records against a transaction-level model.
module tb_memory_stage;
    localparam int TO = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    memory_stage_if ifc();

    memory_stage #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations of one transaction, filled by drive_txn.
    int          obs_busy;
    logic        obs_rdy0, obs_out, obs_stable, obs_stall_ok;
    logic [63:0] obs_addr, obs_wdata, obs_data;
    logic [7:0]  obs_strobe;
    logic [2:0]  obs_size;
    logic        obs_rw, obs_mis, obs_err, obs_rdy_out, obs_dreq_out, obs_stall_out;
    logic [4:0]  obs_dst;
    logic        obs_valid_after, obs_mis_after;

    typedef struct {
        int          busy;
        logic        rw;
        logic [63:0] data;
        logic [4:0]  dst;
        logic        chk;
        logic        mis;
        logic        err_set;
        logic [7:0]  strobe;
    } exp_t;

    // Transaction-level view: what writeback and the bus should see for one record.
    function automatic exp_t model(input logic rd, input logic wr, input logic [63:0] res,
                                   input logic rw, input logic [4:0] dst, input int ok_delay,
                                   input logic [63:0] ld_data);
        exp_t e;
        e.busy = 0; e.rw = 1'b0; e.data = 64'd0; e.dst = dst; e.chk = 1'b0;
        e.mis = 1'b0; e.err_set = 1'b0; e.strobe = rd ? 8'h00 : 8'hFF;
        if (!(rd || wr)) begin
            e.rw = rw && (dst != 0); e.data = res; e.chk = 1'b1;
        end else if (res[2:0] != 3'd0) begin
            e.mis = 1'b1;
        end else if (ok_delay >= 0 && ok_delay < TO) begin
            e.busy = ok_delay + 1; e.chk = 1'b1;
            e.rw = rd && rw && (dst != 0);
            e.data = rd ? ld_data : 64'd0;
        end else begin
            e.busy = TO; e.err_set = 1'b1;
        end
        return e;
    endfunction

    task automatic drive_txn(input logic rd, input logic wr, input logic [63:0] res, input logic [63:0] md,
                             input logic rw, input logic [4:0] dst, input int ok_delay, input logic [63:0] ld_data);
        int guard;
        obs_busy = 0; obs_stable = 1'b1; obs_stall_ok = 1'b1;
        obs_addr = '0; obs_wdata = '0; obs_strobe = '0; obs_size = '0;
        @(negedge clk);
        obs_rdy0 = ifc.in_ready;
        ifc.in_valid = 1'b1; ifc.in_memread = rd; ifc.in_memwrite = wr; ifc.in_result = res;
        ifc.in_memdata = md; ifc.in_regwrite = rw; ifc.in_dst = dst;
        ifc.dresp_data_ok = 1'($urandom_range(0, 1));
        ifc.dresp_data = {$urandom, $urandom};
        @(negedge clk);
        ifc.in_valid = 1'b0;
        guard = 0;
        while (!ifc.out_valid && guard < 200) begin
            ifc.in_result = {$urandom, $urandom};
            ifc.in_memdata = {$urandom, $urandom};
            if (ifc.dreq_valid) begin
                if (obs_busy == 0) begin
                    obs_addr = ifc.dreq_addr; obs_wdata = ifc.dreq_data;
                    obs_strobe = ifc.dreq_strobe; obs_size = ifc.dreq_size;
                end else if (ifc.dreq_addr !== obs_addr || ifc.dreq_data !== obs_wdata ||
                             ifc.dreq_strobe !== obs_strobe || ifc.dreq_size !== obs_size) begin
                    obs_stable = 1'b0;
                end
                if (ifc.stall !== 1'b1 || ifc.in_ready !== 1'b0) obs_stall_ok = 1'b0;
                obs_busy++;
            end
            ifc.dresp_data_ok = ifc.dreq_valid && (obs_busy - 1 == ok_delay);
            ifc.dresp_data = ifc.dresp_data_ok ? ld_data : {$urandom, $urandom};
            @(negedge clk);
            guard++;
        end
        obs_out = ifc.out_valid; obs_rw = ifc.out_regwrite; obs_dst = ifc.out_dst;
        obs_data = ifc.out_regdata; obs_mis = ifc.misalign; obs_err = ifc.bus_err;
        obs_rdy_out = ifc.in_ready; obs_dreq_out = ifc.dreq_valid; obs_stall_out = ifc.stall;
        ifc.dresp_data_ok = 1'b0;
        @(negedge clk);
        obs_valid_after = ifc.out_valid; obs_mis_after = ifc.misalign;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ifc.in_ready !== 1'b1 || ifc.stall !== 1'b0) begin failures++; $display("FAIL reset_ready got in_ready=%b stall=%b exp 1/0", ifc.in_ready, ifc.stall); end
        checks++; if (ifc.dreq_valid !== 1'b0 || ifc.dreq_size !== 3'b011) begin failures++; $display("FAIL reset_dreq got valid=%b size=%b exp 0/011", ifc.dreq_valid, ifc.dreq_size); end
        checks++; if ({ifc.dreq_addr, ifc.dreq_data, ifc.dreq_strobe} !== '0) begin failures++; $display("FAIL reset_dreq_fields got addr=%h data=%h strobe=%h exp 0", ifc.dreq_addr, ifc.dreq_data, ifc.dreq_strobe); end
        checks++; if ({ifc.out_valid, ifc.out_regwrite, ifc.out_dst, ifc.out_regdata} !== '0) begin failures++; $display("FAIL reset_out got valid=%b rw=%b dst=%0d data=%h exp 0", ifc.out_valid, ifc.out_regwrite, ifc.out_dst, ifc.out_regdata); end
        checks++; if (ifc.misalign !== 1'b0 || ifc.bus_err !== 1'b0) begin failures++; $display("FAIL reset_status got mis=%b err=%b exp 0/0", ifc.misalign, ifc.bus_err); end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        drive_txn(1'b0, 1'b0, 64'h1234, 64'd0, 1'b1, 5'd5, -1, 64'd0);
        checks++; if (obs_rdy0 !== 1'b1 || obs_busy !== 0 || obs_stall_out !== 1'b0) begin failures++; $display("FAIL alu_flow got rdy=%b busy=%0d stall=%b exp 1/0/0", obs_rdy0, obs_busy, obs_stall_out); end
        checks++; if (obs_out !== 1'b1 || obs_dst !== 5'd5 || obs_data !== 64'h1234 || obs_rw !== 1'b1) begin failures++; $display("FAIL alu_out got v=%b dst=%0d data=%h rw=%b exp 1/5/1234/1", obs_out, obs_dst, obs_data, obs_rw); end
        checks++; if (obs_valid_after !== 1'b0) begin failures++; $display("FAIL alu_pulse got out_valid=%b next cycle exp 0", obs_valid_after); end
        drive_txn(1'b0, 1'b0, 64'h77, 64'd0, 1'b1, 5'd0, -1, 64'd0);
        checks++; if (obs_out !== 1'b1 || obs_rw !== 1'b0) begin failures++; $display("FAIL alu_dst0 got v=%b rw=%b exp 1/0", obs_out, obs_rw); end
    endtask

    task automatic test_load;
        drive_txn(1'b1, 1'b0, 64'h8000_0010, 64'd0, 1'b1, 5'd7, 2, 64'hDEAD_BEEF);
        checks++; if (obs_busy !== 3 || obs_stable !== 1'b1 || obs_stall_ok !== 1'b1) begin failures++; $display("FAIL ld_busy got busy=%0d stable=%b stall=%b exp 3/1/1", obs_busy, obs_stable, obs_stall_ok); end
        checks++; if (obs_addr !== 64'h8000_0010 || obs_strobe !== 8'h00 || obs_size !== 3'b011) begin failures++; $display("FAIL ld_req got addr=%h strobe=%h size=%b exp 80000010/00/011", obs_addr, obs_strobe, obs_size); end
        checks++; if (obs_out !== 1'b1 || obs_data !== 64'hDEAD_BEEF || obs_rw !== 1'b1 || obs_dst !== 5'd7) begin failures++; $display("FAIL ld_out got v=%b data=%h rw=%b dst=%0d exp 1/deadbeef/1/7", obs_out, obs_data, obs_rw, obs_dst); end
        // both memread and memwrite set behaves as a load
        drive_txn(1'b1, 1'b1, 64'h8000_0040, 64'h5555, 1'b1, 5'd2, 1, 64'h0BAD_F00D);
        checks++; if (obs_busy !== 2 || obs_strobe !== 8'h00 || obs_data !== 64'h0BAD_F00D || obs_rw !== 1'b1) begin failures++; $display("FAIL ldsd_as_ld got busy=%0d strobe=%h data=%h rw=%b exp 2/00/0badf00d/1", obs_busy, obs_strobe, obs_data, obs_rw); end
    endtask

    task automatic test_store;
        drive_txn(1'b0, 1'b1, 64'h8000_0018, 64'hCAFE, 1'b1, 5'd9, 0, 64'h1111);
        checks++; if (obs_busy !== 1 || obs_strobe !== 8'hFF || obs_wdata !== 64'hCAFE || obs_addr !== 64'h8000_0018) begin failures++; $display("FAIL sd_req got busy=%0d strobe=%h data=%h addr=%h exp 1/ff/cafe/80000018", obs_busy, obs_strobe, obs_wdata, obs_addr); end
        checks++; if (obs_out !== 1'b1 || obs_rw !== 1'b0 || obs_data !== 64'd0 || obs_rdy_out !== 1'b1) begin failures++; $display("FAIL sd_out got v=%b rw=%b data=%h rdy=%b exp 1/0/0/1", obs_out, obs_rw, obs_data, obs_rdy_out); end
    endtask

    task automatic test_misalign;
        drive_txn(1'b1, 1'b0, 64'h8000_0003, 64'd0, 1'b1, 5'd4, 0, 64'h2222);
        checks++; if (obs_busy !== 0 || obs_out !== 1'b1 || obs_rw !== 1'b0) begin failures++; $display("FAIL mis_out got busy=%0d v=%b rw=%b exp 0/1/0", obs_busy, obs_out, obs_rw); end
        checks++; if (obs_mis !== 1'b1 || obs_mis_after !== 1'b0 || obs_err !== 1'b0) begin failures++; $display("FAIL mis_pulse got mis=%b after=%b err=%b exp 1/0/0", obs_mis, obs_mis_after, obs_err); end
    endtask

    task automatic test_timeout;
        // data_ok at the last permitted cycle still completes
        drive_txn(1'b1, 1'b0, 64'h8000_0100, 64'd0, 1'b1, 5'd6, TO - 1, 64'hABCD);
        checks++; if (obs_busy !== TO || obs_err !== 1'b0 || obs_data !== 64'hABCD || obs_rw !== 1'b1) begin failures++; $display("FAIL to_edge got busy=%0d err=%b data=%h rw=%b exp %0d/0/abcd/1", obs_busy, obs_err, obs_data, obs_rw, TO); end
        drive_txn(1'b1, 1'b0, 64'h8000_0108, 64'd0, 1'b1, 5'd6, -1, 64'd0);
        checks++; if (obs_busy !== TO || obs_out !== 1'b1 || obs_rw !== 1'b0) begin failures++; $display("FAIL to_out got busy=%0d v=%b rw=%b exp %0d/1/0", obs_busy, obs_out, obs_rw, TO); end
        checks++; if (obs_err !== 1'b1 || obs_dreq_out !== 1'b0) begin failures++; $display("FAIL to_err got err=%b dreq=%b exp 1/0", obs_err, obs_dreq_out); end
        drive_txn(1'b0, 1'b0, 64'h99, 64'd0, 1'b1, 5'd8, -1, 64'd0);
        checks++; if (obs_out !== 1'b1 || obs_data !== 64'h99 || obs_rw !== 1'b1 || obs_err !== 1'b1) begin failures++; $display("FAIL to_after got v=%b data=%h rw=%b err=%b exp 1/99/1/1", obs_out, obs_data, obs_rw, obs_err); end
    endtask

    task automatic test_reset_mid;
        logic seen_out;
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.in_memread = 1'b1; ifc.in_memwrite = 1'b0;
        ifc.in_result = 64'h8000_0020; ifc.in_regwrite = 1'b1; ifc.in_dst = 5'd3;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        checks++; if (ifc.dreq_valid !== 1'b1) begin failures++; $display("FAIL rmid_busy got dreq=%b exp 1", ifc.dreq_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ifc.dreq_valid !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.bus_err !== 1'b0) begin failures++; $display("FAIL rmid_state got dreq=%b v=%b rdy=%b err=%b exp 0/0/1/0", ifc.dreq_valid, ifc.out_valid, ifc.in_ready, ifc.bus_err); end
        ifc.dresp_data_ok = 1'b1; ifc.dresp_data = 64'hFFFF;
        seen_out = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ifc.dresp_data_ok = 1'b0;
            if (ifc.out_valid !== 1'b0 || ifc.dreq_valid !== 1'b0) seen_out = 1'b1;
        end
        checks++; if (seen_out !== 1'b0) begin failures++; $display("FAIL rmid_ignore got spurious out_valid/dreq=%b exp 0", seen_out); end
    endtask

    task automatic test_random;
        exp_t        e;
        logic        m_err;
        logic        rd, wr, rw;
        logic [63:0] res, md, ld;
        logic [4:0]  dst;
        int          kind, dly;
        m_err = 1'b0;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            rd = (kind == 1) || (kind == 3); wr = (kind == 2) || (kind == 3);
            res = {$urandom, $urandom};
            if (kind == 4) begin
                rd = 1'($urandom_range(0, 1)); wr = ~rd;
                res[2:0] = 3'($urandom_range(1, 7));
            end else if (kind != 0) begin
                res[2:0] = 3'd0;
            end
            md = {$urandom, $urandom}; ld = {$urandom, $urandom};
            rw = 1'($urandom_range(0, 3) != 0);
            dst = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            dly = int'($urandom_range(0, 6)) - 1;
            e = model(rd, wr, res, rw, dst, dly, ld);
            m_err = m_err | e.err_set;
            drive_txn(rd, wr, res, md, rw, dst, dly, ld);
            checks++; if (obs_out !== 1'b1 || obs_busy !== e.busy || obs_valid_after !== 1'b0) begin failures++; $display("FAIL rnd_flow n=%0d got v=%b busy=%0d after=%b exp 1/%0d/0", n, obs_out, obs_busy, obs_valid_after, e.busy); end
            checks++; if (obs_rw !== e.rw || obs_mis !== e.mis || obs_err !== m_err) begin failures++; $display("FAIL rnd_status n=%0d got rw=%b mis=%b err=%b exp %b/%b/%b", n, obs_rw, obs_mis, obs_err, e.rw, e.mis, m_err); end
            checks++; if (obs_rdy_out !== 1'b1 || obs_dreq_out !== 1'b0 || obs_stall_ok !== 1'b1 || obs_stable !== 1'b1) begin failures++; $display("FAIL rnd_hs n=%0d got rdy=%b dreq=%b stall=%b stable=%b exp 1/0/1/1", n, obs_rdy_out, obs_dreq_out, obs_stall_ok, obs_stable); end
            if (e.chk) begin
                checks++; if (obs_data !== e.data || obs_dst !== e.dst) begin failures++; $display("FAIL rnd_data n=%0d got data=%h dst=%0d exp %h/%0d", n, obs_data, obs_dst, e.data, e.dst); end
            end
            if (e.busy > 0) begin
                checks++; if (obs_addr !== res || obs_strobe !== e.strobe || obs_size !== 3'b011 || (wr && !rd && obs_wdata !== md)) begin failures++; $display("FAIL rnd_req n=%0d got addr=%h strobe=%h size=%b wdata=%h exp %h/%h/011/%h", n, obs_addr, obs_strobe, obs_size, obs_wdata, res, e.strobe, md); end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_result = '0; ifc.in_memdata = '0; ifc.in_memread = 1'b0;
        ifc.in_memwrite = 1'b0; ifc.in_regwrite = 1'b0; ifc.in_dst = '0;
        ifc.dresp_data_ok = 1'b0; ifc.dresp_data = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
